// File: rtl/rf_pkg.sv
// Shared types and constants for the register-file write-back arbiter.
package rf_pkg;

  typedef logic [4:0]  regaddr_t;
  typedef logic [31:0] word_t;

  typedef struct packed {
    regaddr_t rd;
    word_t    data;
  } wb_entry_t;

  localparam regaddr_t REG_ZERO = 5'd0;

  function automatic logic is_nonzero(input regaddr_t r);
    return (r != REG_ZERO);
  endfunction

endpackage

// File: rtl/rf_wb_fifo.sv
// Circular buffer holding MDU results while the pipeline owns the write port.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module rf_wb_fifo
  import rf_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  wb_entry_t push_data,
  input  logic      pop,
  output wb_entry_t head,
  output logic      full,
  output logic      empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  wb_entry_t     mem_q [DEPTH];
  logic          pop_ok_s;
  logic          push_ok_s;

  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop_ok_s  = pop && !empty;
  assign push_ok_s = push && (!full || pop_ok_s);
  assign head      = mem_q[rd_ptr_q[AW-1:0]];

  // Pointer advance for push and pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok_s) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_ok_s) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
  end

  // Pointer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Entry storage; contents are qualified by the pointers, so no reset needed.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_q[wr_ptr_q[AW-1:0]] <= push_data;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Owns the regfile write port: pipeline writeback beats buffered MDU results,
// tracks in-flight MDU destinations and drives the decode stall.
module regfile_wb_arbiter
  import rf_pkg::*;
#(
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_valid,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  input  logic        issue_valid,
  input  logic [4:0]  issue_rd,
  output logic        issue_ready,
  input  logic        mdu_valid,
  input  logic [4:0]  mdu_rd,
  input  logic [31:0] mdu_data,
  output logic        mdu_ready,
  input  logic [4:0]  dec_rs1,
  input  logic [4:0]  dec_rs2,
  input  logic [4:0]  dec_rd,
  input  logic        dec_valid,
  output logic        stall,
  output logic        drain_req,
  output logic        rf_we3,
  output logic [4:0]  rf_ad3,
  output logic [31:0] rf_wd3
);

  localparam int            CW      = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_LIMIT);

  logic [31:0]   pending_q, pending_d;
  logic [31:0]   pending_clr_q, pending_clr_d;
  logic [CW-1:0] starve_q, starve_d;
  logic          drain_q, drain_d;
  logic          rf_we_q, rf_we_d;
  regaddr_t      rf_ad_q, rf_ad_d;
  word_t         rf_wd_q, rf_wd_d;

  logic          wb_sel_s, pop_s, push_s, full_s, empty_s, issue_acc_s;
  logic [31:0]   hazard_s;
  wb_entry_t     head_s, push_entry_s;

  rf_wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_s),
    .push_data (push_entry_s),
    .pop       (pop_s),
    .head      (head_s),
    .full      (full_s),
    .empty     (empty_s)
  );

  assign wb_sel_s     = wb_valid && is_nonzero(wb_rd);
  assign pop_s        = !wb_sel_s && !empty_s;
  assign mdu_ready    = !rst && (!full_s || pop_s);
  assign push_s       = mdu_valid && mdu_ready && is_nonzero(mdu_rd);
  assign push_entry_s = '{rd: mdu_rd, data: mdu_data};
  assign issue_ready  = !rst && !(is_nonzero(issue_rd) && pending_q[issue_rd]);
  assign issue_acc_s  = issue_valid && issue_ready && is_nonzero(issue_rd);

  // A register stays hazardous one extra cycle after its pending bit clears,
  // until its regfile write has landed on the following negedge.
  assign hazard_s = pending_q | pending_clr_q;
  assign stall    = (dec_valid && ((is_nonzero(dec_rs1) && hazard_s[dec_rs1]) ||
                                   (is_nonzero(dec_rs2) && hazard_s[dec_rs2]) ||
                                   (is_nonzero(dec_rd)  && hazard_s[dec_rd]))) || drain_q;

  assign drain_req = drain_q;
  assign rf_we3    = rf_we_q;
  assign rf_ad3    = rf_ad_q;
  assign rf_wd3    = rf_wd_q;

  // Port arbitration, scoreboard update and starvation counting.
  always_comb begin
    pending_d     = pending_q;
    pending_clr_d = 32'd0;
    rf_we_d       = 1'b0;
    rf_ad_d       = rf_ad_q;
    rf_wd_d       = rf_wd_q;
    if (wb_sel_s) begin
      rf_we_d = 1'b1;
      rf_ad_d = wb_rd;
      rf_wd_d = wb_data;
    end else if (pop_s) begin
      rf_we_d                  = 1'b1;
      rf_ad_d                  = head_s.rd;
      rf_wd_d                  = head_s.data;
      pending_d[head_s.rd]     = 1'b0;
      pending_clr_d[head_s.rd] = 1'b1;
    end else begin
      rf_we_d = 1'b0;
    end
    pending_d = pending_d | (issue_acc_s ? (32'd1 << issue_rd) : 32'd0);

    if (empty_s || pop_s) begin
      starve_d = '0;
    end else if (starve_q != CNT_MAX) begin
      starve_d = starve_q + CW'(1);
    end else begin
      starve_d = starve_q;
    end
    drain_d = (starve_d >= CNT_MAX);
  end

  // State and registered write-port outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q     <= 32'd0;
      pending_clr_q <= 32'd0;
      starve_q      <= '0;
      drain_q       <= 1'b0;
      rf_we_q       <= 1'b0;
      rf_ad_q       <= REG_ZERO;
      rf_wd_q       <= 32'd0;
    end else begin
      pending_q     <= pending_d;
      pending_clr_q <= pending_clr_d;
      starve_q      <= starve_d;
      drain_q       <= drain_d;
      rf_we_q       <= rf_we_d;
      rf_ad_q       <= rf_ad_d;
      rf_wd_q       <= rf_wd_d;
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed scenarios plus a randomized run against a queue-based reference model.
module tb_regfile_wb_arbiter;
  import rf_pkg::*;

  localparam int FIFO_DEPTH   = 2;
  localparam int STARVE_LIMIT = 4;

  logic        clk, rst;
  logic        wb_valid, issue_valid, mdu_valid, dec_valid;
  logic [4:0]  wb_rd, issue_rd, mdu_rd, dec_rs1, dec_rs2, dec_rd;
  logic [31:0] wb_data, mdu_data;
  logic        issue_ready, mdu_ready, stall, drain_req, rf_we3;
  logic [4:0]  rf_ad3;
  logic [31:0] rf_wd3;

  int errors = 0;
  int checks = 0;

  regfile_wb_arbiter #(.FIFO_DEPTH(FIFO_DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk(clk), .rst(rst),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
    .mdu_valid(mdu_valid), .mdu_rd(mdu_rd), .mdu_data(mdu_data), .mdu_ready(mdu_ready),
    .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd), .dec_valid(dec_valid),
    .stall(stall), .drain_req(drain_req),
    .rf_we3(rf_we3), .rf_ad3(rf_ad3), .rf_wd3(rf_wd3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic idle();
    wb_valid = 1'b0; wb_rd = 5'd0; wb_data = 32'd0;
    issue_valid = 1'b0; issue_rd = 5'd0;
    mdu_valid = 1'b0; mdu_rd = 5'd0; mdu_data = 32'd0;
    dec_valid = 1'b0; dec_rs1 = 5'd0; dec_rs2 = 5'd0; dec_rd = 5'd0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; idle();
    issue_valid = 1'b1; issue_rd = 5'd5; mdu_valid = 1'b1; mdu_rd = 5'd3;
    dec_valid = 1'b1; dec_rs1 = 5'd5;
    #1;
    checks++; if (issue_ready !== 1'b0) begin errors++; $display("FAIL rst_issue_ready: got %b want 0", issue_ready); end
    checks++; if (mdu_ready !== 1'b0) begin errors++; $display("FAIL rst_mdu_ready: got %b want 0", mdu_ready); end
    tick();
    checks++; if (rf_we3 !== 1'b0) begin errors++; $display("FAIL rst_we: got %b want 0", rf_we3); end
    checks++; if (rf_ad3 !== 5'd0) begin errors++; $display("FAIL rst_ad: got %0d want 0", rf_ad3); end
    checks++; if (rf_wd3 !== 32'd0) begin errors++; $display("FAIL rst_wd: got %0h want 0", rf_wd3); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rst_stall: got %b want 0", stall); end
    checks++; if (drain_req !== 1'b0) begin errors++; $display("FAIL rst_drain: got %b want 0", drain_req); end
    idle(); rst = 1'b0;
    tick();
  endtask

  task automatic test_raw_stall();
    issue_valid = 1'b1; issue_rd = 5'd5;
    #1;
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL raw_issue_ready: got %b want 1", issue_ready); end
    tick();
    idle(); dec_valid = 1'b1; dec_rs1 = 5'd5;
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL raw_stall_rs1: got %b want 1", stall); end
    dec_rs1 = 5'd0; dec_rd = 5'd5;
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL raw_stall_waw: got %b want 1", stall); end
    dec_rd = 5'd0; dec_rs1 = 5'd5;
    mdu_valid = 1'b1; mdu_rd = 5'd5; mdu_data = 32'h0000_1234;
    #1;
    checks++; if (mdu_ready !== 1'b1) begin errors++; $display("FAIL raw_mdu_ready: got %b want 1", mdu_ready); end
    tick();
    mdu_valid = 1'b0;
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL raw_stall_buffered: got %b want 1", stall); end
    tick();
    checks++; if (rf_we3 !== 1'b1) begin errors++; $display("FAIL raw_we: got %b want 1", rf_we3); end
    checks++; if (rf_ad3 !== 5'd5) begin errors++; $display("FAIL raw_ad: got %0d want 5", rf_ad3); end
    checks++; if (rf_wd3 !== 32'h0000_1234) begin errors++; $display("FAIL raw_wd: got %0h want 1234", rf_wd3); end
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL raw_stall_hold: got %b want 1", stall); end
    tick();
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL raw_stall_release: got %b want 0", stall); end
    checks++; if (rf_we3 !== 1'b0) begin errors++; $display("FAIL raw_we_idle: got %b want 0", rf_we3); end
    checks++; if (rf_ad3 !== 5'd5 || rf_wd3 !== 32'h0000_1234) begin errors++; $display("FAIL raw_hold: got %0d/%0h want 5/1234", rf_ad3, rf_wd3); end
    idle();
  endtask

  task automatic test_priority();
    wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 32'h0000_00AA;
    mdu_valid = 1'b1; mdu_rd = 5'd7; mdu_data = 32'h0000_00BB;
    tick();
    idle();
    checks++; if (rf_we3 !== 1'b1 || rf_ad3 !== 5'd3 || rf_wd3 !== 32'h0000_00AA) begin errors++; $display("FAIL prio_wb: got %b/%0d/%0h want 1/3/aa", rf_we3, rf_ad3, rf_wd3); end
    tick();
    checks++; if (rf_we3 !== 1'b1 || rf_ad3 !== 5'd7 || rf_wd3 !== 32'h0000_00BB) begin errors++; $display("FAIL prio_mdu: got %b/%0d/%0h want 1/7/bb", rf_we3, rf_ad3, rf_wd3); end
    tick();
    checks++; if (rf_we3 !== 1'b0) begin errors++; $display("FAIL prio_idle: got %b want 0", rf_we3); end
  endtask

  task automatic test_backpressure_drain();
    wb_valid = 1'b1; wb_rd = 5'd1; wb_data = 32'h0000_0100;
    mdu_valid = 1'b1; mdu_rd = 5'd10; mdu_data = 32'h0000_010A;
    #1;
    checks++; if (mdu_ready !== 1'b1) begin errors++; $display("FAIL bp_ready0: got %b want 1", mdu_ready); end
    tick();
    mdu_rd = 5'd11; mdu_data = 32'h0000_010B;
    #1;
    checks++; if (mdu_ready !== 1'b1) begin errors++; $display("FAIL bp_ready1: got %b want 1", mdu_ready); end
    tick();
    mdu_rd = 5'd12; mdu_data = 32'h0000_010C;
    #1;
    checks++; if (mdu_ready !== 1'b0) begin errors++; $display("FAIL bp_full: got %b want 0", mdu_ready); end
    tick();
    mdu_valid = 1'b0;
    checks++; if (rf_we3 !== 1'b1 || rf_ad3 !== 5'd1) begin errors++; $display("FAIL bp_wb_owns: got %b/%0d want 1/1", rf_we3, rf_ad3); end
    checks++; if (drain_req !== 1'b0) begin errors++; $display("FAIL bp_drain_early2: got %b want 0", drain_req); end
    tick();
    checks++; if (drain_req !== 1'b0) begin errors++; $display("FAIL bp_drain_early3: got %b want 0", drain_req); end
    tick();
    checks++; if (drain_req !== 1'b1) begin errors++; $display("FAIL bp_drain: got %b want 1", drain_req); end
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL bp_drain_stall: got %b want 1", stall); end
    wb_valid = 1'b0; mdu_valid = 1'b1; mdu_rd = 5'd12; mdu_data = 32'h0000_010C;
    #1;
    checks++; if (mdu_ready !== 1'b1) begin errors++; $display("FAIL bp_full_pop_ready: got %b want 1", mdu_ready); end
    tick();
    mdu_valid = 1'b0;
    checks++; if (rf_we3 !== 1'b1 || rf_ad3 !== 5'd10 || rf_wd3 !== 32'h0000_010A) begin errors++; $display("FAIL bp_pop10: got %b/%0d/%0h want 1/10/10a", rf_we3, rf_ad3, rf_wd3); end
    checks++; if (drain_req !== 1'b0) begin errors++; $display("FAIL bp_drain_clear: got %b want 0", drain_req); end
    tick();
    checks++; if (rf_ad3 !== 5'd11 || rf_wd3 !== 32'h0000_010B) begin errors++; $display("FAIL bp_pop11: got %0d/%0h want 11/10b", rf_ad3, rf_wd3); end
    tick();
    checks++; if (rf_ad3 !== 5'd12 || rf_wd3 !== 32'h0000_010C) begin errors++; $display("FAIL bp_pop12: got %0d/%0h want 12/10c", rf_ad3, rf_wd3); end
    tick();
    checks++; if (rf_we3 !== 1'b0) begin errors++; $display("FAIL bp_empty: got %b want 0", rf_we3); end
    idle();
  endtask

  task automatic test_issue_block_rd0();
    issue_valid = 1'b1; issue_rd = 5'd9;
    #1;
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL blk_first: got %b want 1", issue_ready); end
    tick();
    #1;
    checks++; if (issue_ready !== 1'b0) begin errors++; $display("FAIL blk_pending: got %b want 0", issue_ready); end
    issue_rd = 5'd0;
    #1;
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL blk_rd0: got %b want 1", issue_ready); end
    issue_valid = 1'b0;
    mdu_valid = 1'b1; mdu_rd = 5'd0; mdu_data = 32'h0000_DEAD;
    #1;
    checks++; if (mdu_ready !== 1'b1) begin errors++; $display("FAIL blk_mdu0_ready: got %b want 1", mdu_ready); end
    tick();
    mdu_valid = 1'b0;
    checks++; if (rf_we3 !== 1'b0) begin errors++; $display("FAIL blk_mdu0_we1: got %b want 0", rf_we3); end
    tick();
    checks++; if (rf_we3 !== 1'b0) begin errors++; $display("FAIL blk_mdu0_we2: got %b want 0", rf_we3); end
    mdu_valid = 1'b1; mdu_rd = 5'd9; mdu_data = 32'h0000_0099;
    tick();
    mdu_valid = 1'b0;
    tick();
    checks++; if (rf_we3 !== 1'b1 || rf_ad3 !== 5'd9 || rf_wd3 !== 32'h0000_0099) begin errors++; $display("FAIL blk_ret9: got %b/%0d/%0h want 1/9/99", rf_we3, rf_ad3, rf_wd3); end
    issue_rd = 5'd9;
    #1;
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL blk_unblocked: got %b want 1", issue_ready); end
    idle();
    tick();
  endtask

  task automatic test_wb_rd0_pop();
    wb_valid = 1'b1; wb_rd = 5'd2; wb_data = 32'h0000_0022;
    mdu_valid = 1'b1; mdu_rd = 5'd13; mdu_data = 32'h0000_1313;
    tick();
    mdu_valid = 1'b0; wb_rd = 5'd0; wb_data = 32'h0000_FFFF;
    tick();
    checks++; if (rf_ad3 === 5'd0) begin errors++; $display("FAIL rd0_ad_nonzero: got %0d want nonzero", rf_ad3); end
    checks++; if (rf_we3 !== 1'b1 || rf_ad3 !== 5'd13 || rf_wd3 !== 32'h0000_1313) begin errors++; $display("FAIL rd0_pop: got %b/%0d/%0h want 1/13/1313", rf_we3, rf_ad3, rf_wd3); end
    idle();
    tick();
    checks++; if (rf_we3 !== 1'b0) begin errors++; $display("FAIL rd0_after: got %b want 0", rf_we3); end
  endtask

  task automatic test_reset_midflight();
    issue_valid = 1'b1; issue_rd = 5'd4;
    tick();
    issue_rd = 5'd6;
    wb_valid = 1'b1; wb_rd = 5'd2; wb_data = 32'h0000_0022;
    mdu_valid = 1'b1; mdu_rd = 5'd4; mdu_data = 32'h0000_0044;
    tick();
    issue_valid = 1'b0; mdu_valid = 1'b0;
    dec_valid = 1'b1; dec_rs1 = 5'd6;
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL mid_stall_before: got %b want 1", stall); end
    rst = 1'b1;
    #1;
    checks++; if (rf_we3 !== 1'b0 || rf_ad3 !== 5'd0 || rf_wd3 !== 32'd0) begin errors++; $display("FAIL mid_rst_rf: got %b/%0d/%0h want 0/0/0", rf_we3, rf_ad3, rf_wd3); end
    checks++; if (stall !== 1'b0 || drain_req !== 1'b0) begin errors++; $display("FAIL mid_rst_stall: got %b/%b want 0/0", stall, drain_req); end
    checks++; if (issue_ready !== 1'b0 || mdu_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_ready: got %b/%b want 0/0", issue_ready, mdu_ready); end
    wb_valid = 1'b0;
    tick();
    rst = 1'b0;
    dec_rs1 = 5'd6; dec_rd = 5'd4; issue_rd = 5'd4;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL mid_stall_after: got %b want 0", stall); end
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL mid_issue_after: got %b want 1", issue_ready); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (rf_we3 !== 1'b0) begin errors++; $display("FAIL mid_no_write%0d: got %b want 0", i, rf_we3); end
    end
    idle();
  endtask

  task automatic test_random();
    bit        pend [32];
    bit        clr  [32];
    wb_entry_t q [$];
    regaddr_t  infl [$];
    wb_entry_t e;
    int        cnt, k;
    bit        drain, e_we, wbsel, pop, e_mr, e_ir, e_st, was_ne;
    regaddr_t  e_ad;
    word_t     e_wd;

    rst = 1'b1; idle(); tick(); rst = 1'b0;
    foreach (pend[i]) begin pend[i] = 1'b0; clr[i] = 1'b0; end
    cnt = 0; drain = 1'b0; e_we = 1'b0; e_ad = 5'd0; e_wd = 32'd0;

    for (int c = 0; c < 400; c++) begin
      wb_valid = ($urandom_range(0, 1) == 1);
      wb_rd    = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      wb_data  = $urandom;
      issue_valid = ($urandom_range(0, 2) == 0);
      issue_rd    = 5'($urandom_range(0, 31));
      k = -1;
      if (infl.size() > 0 && $urandom_range(0, 1) == 1) begin
        k = $urandom_range(0, infl.size() - 1);
        mdu_valid = 1'b1; mdu_rd = infl[k];
      end else if ($urandom_range(0, 7) == 0) begin
        mdu_valid = 1'b1; mdu_rd = 5'd0;
      end else begin
        mdu_valid = 1'b0; mdu_rd = 5'($urandom_range(0, 31));
      end
      mdu_data  = $urandom;
      dec_valid = ($urandom_range(0, 1) == 1);
      dec_rs1 = 5'($urandom_range(0, 31));
      dec_rs2 = 5'($urandom_range(0, 31));
      dec_rd  = 5'($urandom_range(0, 31));
      #1;

      wbsel = wb_valid && (wb_rd != 5'd0);
      pop   = !wbsel && (q.size() > 0);
      e_mr  = (q.size() < FIFO_DEPTH) || pop;
      e_ir  = !((issue_rd != 5'd0) && pend[issue_rd]);
      e_st  = drain || (dec_valid && ((dec_rs1 != 5'd0 && (pend[dec_rs1] || clr[dec_rs1])) ||
                                      (dec_rs2 != 5'd0 && (pend[dec_rs2] || clr[dec_rs2])) ||
                                      (dec_rd  != 5'd0 && (pend[dec_rd]  || clr[dec_rd]))));
      checks++; if (mdu_ready !== e_mr) begin errors++; $display("FAIL rnd_mdu_ready c%0d: got %b want %b", c, mdu_ready, e_mr); end
      checks++; if (issue_ready !== e_ir) begin errors++; $display("FAIL rnd_issue_ready c%0d: got %b want %b", c, issue_ready, e_ir); end
      checks++; if (stall !== e_st) begin errors++; $display("FAIL rnd_stall c%0d: got %b want %b", c, stall, e_st); end

      was_ne = (q.size() > 0);
      foreach (clr[i]) clr[i] = 1'b0;
      if (wbsel) begin
        e_we = 1'b1; e_ad = wb_rd; e_wd = wb_data;
      end else if (pop) begin
        e = q.pop_front();
        e_we = 1'b1; e_ad = e.rd; e_wd = e.data;
        pend[e.rd] = 1'b0; clr[e.rd] = 1'b1;
      end else begin
        e_we = 1'b0;
      end
      if (mdu_valid && e_mr) begin
        if (k >= 0) infl.delete(k);
        if (mdu_rd != 5'd0) q.push_back('{rd: mdu_rd, data: mdu_data});
      end
      if (issue_valid && e_ir && issue_rd != 5'd0) begin
        pend[issue_rd] = 1'b1;
        infl.push_back(issue_rd);
      end
      if (!was_ne || pop) cnt = 0;
      else if (cnt < STARVE_LIMIT) cnt++;
      drain = (cnt >= STARVE_LIMIT);

      tick();
      checks++; if (rf_we3 !== e_we) begin errors++; $display("FAIL rnd_we c%0d: got %b want %b", c, rf_we3, e_we); end
      checks++; if (rf_ad3 !== e_ad || rf_wd3 !== e_wd) begin errors++; $display("FAIL rnd_ad_wd c%0d: got %0d/%0h want %0d/%0h", c, rf_ad3, rf_wd3, e_ad, e_wd); end
      checks++; if (drain_req !== drain) begin errors++; $display("FAIL rnd_drain c%0d: got %b want %b", c, drain_req, drain); end
    end
    idle();
  endtask

  initial begin
    rst = 1'b1;
    idle();
    test_reset();
    test_raw_stall();
    test_priority();
    test_backpressure_drain();
    test_issue_block_rd0();
    test_wb_rd0_pop();
    test_reset_midflight();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
